// File: rtl/alu_result_stage.sv
// ALU result stage: flags, 2-entry skid FIFO, sticky overflow and pop counter.
// Optional: define ALU_RES_PARITY_EN to add a parity bit P as out_flags[4].
module alu_result_stage #(
    parameter int          WIDTH      = 16,
    parameter logic [15:0] ARITH_MASK = 16'h000F,
    parameter int          DEPTH      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_op,
    input  logic             in_carry,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_op,
`ifdef ALU_RES_PARITY_EN
    output logic [4:0]       out_flags,
`else
    output logic [3:0]       out_flags,
`endif
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [15:0]      res_count
);

`ifdef ALU_RES_PARITY_EN
    localparam int FW = 5;
`else
    localparam int FW = 4;
`endif

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] head_res_q, head_res_d, tail_res_q, tail_res_d;
    logic [3:0]       head_op_q, head_op_d, tail_op_q, tail_op_d;
    logic [FW-1:0]    head_flg_q, head_flg_d, tail_flg_q, tail_flg_d;
    logic             sticky_q, sticky_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [FW-1:0]    in_flags;
    logic             push, pop;

    // C and V only carry meaning for arithmetic opcodes
    always_comb begin
        in_flags[3] = in_result[WIDTH-1];
        in_flags[2] = (in_result == '0);
        in_flags[1] = in_carry & ARITH_MASK[in_op];
        in_flags[0] = in_ovf & ARITH_MASK[in_op];
`ifdef ALU_RES_PARITY_EN
        in_flags[4] = ^in_result;
`endif
    end

    assign in_ready  = (int'(state_q) < DEPTH);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        head_res_d = head_res_q;
        head_op_d  = head_op_q;
        head_flg_d = head_flg_q;
        tail_res_d = tail_res_q;
        tail_op_d  = tail_op_q;
        tail_flg_d = tail_flg_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_res_d = in_result;
                    head_op_d  = in_op;
                    head_flg_d = in_flags;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_res_d = in_result;
                    head_op_d  = in_op;
                    head_flg_d = in_flags;
                end else if (push) begin
                    tail_res_d = in_result;
                    tail_op_d  = in_op;
                    tail_flg_d = in_flags;
                    state_d    = FULL;
                end else if (pop) begin
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_res_d = tail_res_q;
                    head_op_d  = tail_op_q;
                    head_flg_d = tail_flg_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        sticky_d = sticky_q;
        if (pop && head_flg_q[0])
            sticky_d = 1'b1;
        else if (clr_sticky)
            sticky_d = 1'b0;
        cnt_d = cnt_q + {15'd0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_res_q <= '0;
            head_op_q  <= '0;
            head_flg_q <= '0;
            tail_res_q <= '0;
            tail_op_q  <= '0;
            tail_flg_q <= '0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_res_q <= head_res_d;
            head_op_q  <= head_op_d;
            head_flg_q <= head_flg_d;
            tail_res_q <= tail_res_d;
            tail_op_q  <= tail_op_d;
            tail_flg_q <= tail_flg_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_result = head_res_q;
    assign out_op     = head_op_q;
    assign out_flags  = head_flg_q;
    assign sticky_ovf = sticky_q;
    assign res_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue scoreboard and reference model.
module tb_alu_result_stage;

`ifdef ALU_RES_PARITY_EN
    localparam int FW = 5;
`else
    localparam int FW = 4;
`endif

    typedef struct packed {
        logic [15:0]   r;
        logic [3:0]    op;
        logic [FW-1:0] f;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, in_carry, in_ovf;
    logic [15:0]   in_result, out_result, res_count;
    logic [3:0]    in_op, out_op;
    logic [FW-1:0] out_flags;
    logic          out_valid, out_ready, clr_sticky, sticky_ovf;

    ent_t        sb[$];
    logic [15:0] mask = 16'h000F;
    logic [15:0] m_cnt;
    logic        m_sticky;
    int          vectors = 0;
    int          miscompares = 0;

    alu_result_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_op(in_op),
        .in_carry(in_carry), .in_ovf(in_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op),
        .out_flags(out_flags), .clr_sticky(clr_sticky),
        .sticky_ovf(sticky_ovf), .res_count(res_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic ent_t model(input logic [15:0] r, input logic [3:0] op,
                                   input logic c, input logic o);
        ent_t e;
        e.r = r;
        e.op = op;
        e.f[3] = r[15];
        e.f[2] = (r == 16'h0000);
        e.f[1] = c & mask[op];
        e.f[0] = o & mask[op];
`ifdef ALU_RES_PARITY_EN
        e.f[4] = ^r;
`endif
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_op = '0;
        in_carry = 1'b0; in_ovf = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = '0;
        m_sticky = 1'b0;
    endtask

    task automatic step(input logic v, input logic [15:0] r, input logic [3:0] op,
                        input logic c, input logic o, input logic ordy,
                        input logic clr, input bit check);
        logic push, pop;
        ent_t e;
        in_valid = v; in_result = r; in_op = op; in_carry = c; in_ovf = o;
        out_ready = ordy; clr_sticky = clr;
        #1;
        push = v & in_ready;
        pop = out_valid & ordy;
        if (pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
                e = '0;
            end else begin
                e = sb.pop_front();
            end
            if (check) begin
                chk("pop_result", {16'd0, out_result}, {16'd0, e.r});
                chk("pop_op", {28'd0, out_op}, {28'd0, e.op});
                chk("pop_flags", 32'(out_flags), 32'(e.f));
            end
            m_cnt = m_cnt + 16'd1;
            if (e.f[0]) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
        end else if (clr) begin
            m_sticky = 1'b0;
        end
        if (push) sb.push_back(model(r, op, c, o));
        @(posedge clk); #1;
        in_valid = 1'b0; clr_sticky = 1'b0;
        if (check) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
            chk("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sticky});
            chk("res_count", {16'd0, res_count}, {16'd0, m_cnt});
        end
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_result", {16'd0, out_result}, 32'd0);
        chk("rst_out_op", {28'd0, out_op}, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
        chk("rst_count", {16'd0, res_count}, 32'd0);

        // zero result with a non-arithmetic opcode
        step(1, 16'h0000, 4'd5, 1, 1, 0, 0, 1);
        chk("t1_flags", {28'd0, out_flags[3:0]}, 32'h4);

        do_reset();
        step(1, 16'h8000, 4'd0, 1, 1, 1, 0, 1);
        chk("t2_flags", {28'd0, out_flags[3:0]}, 32'hB);
        step(0, 16'h0, 4'd0, 0, 0, 1, 0, 1);
        chk("t2_sticky", {31'd0, sticky_ovf}, 32'd1);
        chk("t2_count", {16'd0, res_count}, 32'd1);
        step(0, 16'h0, 4'd0, 0, 0, 0, 1, 1);

        // back-pressure: third push is refused
        step(1, 16'h1111, 4'd2, 0, 0, 0, 0, 1);
        step(1, 16'h2222, 4'd7, 0, 0, 0, 0, 1);
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        step(1, 16'h3333, 4'd9, 0, 0, 0, 0, 1);
        chk("t3_hold_a", {16'd0, out_result}, 32'h1111);
        step(0, 16'h0, 4'd0, 0, 0, 1, 0, 1);
        chk("t3_head_b", {16'd0, out_result}, 32'h2222);
        step(0, 16'h0, 4'd0, 0, 0, 1, 0, 1);

        // simultaneous push and pop at occupancy one
        step(1, 16'h1234, 4'd1, 1, 0, 0, 0, 1);
        step(1, 16'h00FF, 4'd3, 0, 0, 1, 0, 1);
        chk("t4_head", {16'd0, out_result}, 32'h00FF);
        step(0, 16'h0, 4'd0, 0, 0, 1, 0, 1);

        // set beats clear
        step(1, 16'h0001, 4'd1, 0, 1, 0, 0, 1);
        step(0, 16'h0, 4'd0, 0, 0, 1, 1, 1);
        chk("t5_set_wins", {31'd0, sticky_ovf}, 32'd1);
        step(0, 16'h0, 4'd0, 0, 0, 0, 1, 1);
        chk("t5_cleared", {31'd0, sticky_ovf}, 32'd0);

        // count wrap
        step(1, 16'h0042, 4'hA, 0, 0, 0, 0, 0);
        while (m_cnt != 16'hFFFF)
            step(1, m_cnt, 4'hA, 0, 0, 1, 0, 0);
        chk("t6_pre_wrap", {16'd0, res_count}, 32'hFFFF);
        step(0, 16'h0, 4'd0, 0, 0, 1, 0, 1);
        chk("t6_wrap", {16'd0, res_count}, 32'd0);

        // reset while full
        step(1, 16'hAAAA, 4'd4, 0, 0, 0, 0, 1);
        step(1, 16'h5555, 4'd6, 0, 0, 0, 0, 1);
        chk("t7_full", {31'd0, in_ready}, 32'd0);
        do_reset();
        chk("t7_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t7_count", {16'd0, res_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the ALU 16:1 result multiplexer.
- Captures the selected 16-bit result and the 4-bit opcode that drove the mux select.
- Computes N/Z/C/V flags and buffers result+flags in a 2-entry skid FIFO with valid/ready handshake toward the writeback/MCU side.
- Maintains a sticky-overflow bit and a result counter for the MCU status register.

Parameters:
- WIDTH, 16, datapath width; matches the mux output width.
- ARITH_MASK, 16'h000F, bit i=1 means opcode i is arithmetic: C/V pass through; otherwise C and V are forced 0.
- DEPTH, 2, buffer entries; fixed at 2; other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  mux output and side info valid
- in_ready  out  1  stage can accept this cycle
- in_result  in  WIDTH  mux output
- in_op  in  4  opcode, the same value as the mux select
- in_carry  in  1  raw carry from the adder unit
- in_ovf  in  1  raw signed overflow from the adder unit
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_result  out  WIDTH  head result
- out_op  out  4  head opcode
- out_flags  out  4  {N,Z,C,V} of head
- clr_sticky  in  1  clear sticky overflow
- sticky_ovf  out  1  set when any popped entry had V=1
- res_count  out  16  number of entries popped, wraps

Behaviour:
- Reset (rst=1 at a clk edge) sets: occupancy=0, out_valid=0, out_result=0, out_op=0, out_flags=0, sticky_ovf=0, res_count=0, in_ready=1.
  - Reset mid-operation discards both entries.
  - Reset has priority over all other inputs.
- Flag computation, combinational on input, stored with the entry:
  - N = in_result[WIDTH-1]
  - Z = (in_result == 0)
  - C = in_carry & ARITH_MASK[in_op]
  - V = in_ovf & ARITH_MASK[in_op]
- Push: occurs when in_valid & in_ready. Pop: occurs when out_valid & out_ready.
- Latency: an entry pushed at edge k is visible on the out_* ports after edge k (1 cycle) if the buffer was empty.
- in_ready = (occupancy < 2). It is registered-equivalent: it depends only on state, not on out_ready.
- Occupancy states and transitions:
  - EMPTY: push → ONE.
  - ONE:
    - push & !pop → FULL
    - pop & !push → EMPTY
    - push & pop → ONE, with the new entry becoming the head.
  - FULL: pop → ONE, with the second entry moving to head. No push is possible.
- Ordering is strict FIFO. out_* ports are stable while out_valid=1 & out_ready=0.
- When out_valid=0, out_result/out_op/out_flags hold their last values (0 after reset).
- sticky_ovf: set on a pop whose V=1; cleared by clr_sticky. If both happen in the same cycle, set wins.
- res_count: increments by 1 on each pop; wraps 16'hFFFF → 0.

Optional Feature:
- Macro: ALU_RES_PARITY_EN.
- Defined:
  - out_flags widens to 5 bits {P,N,Z,C,V}, where P = ^in_result (even-parity bit, 1 when an odd number of ones), stored per entry.
  - The reset value of P is 0.
- Undefined: out_flags is 4 bits and no parity logic is present.

Test Plan:
- Reset then single push of in_result=16'h0000, in_op=4'd5, in_carry=1, in_ovf=1 → next cycle out_valid=1, out_flags={N0,Z1,C0,V0} (op 5 is not arithmetic).
- Push 16'h8000, op=0, carry=1, ovf=1, with out_ready=1 → out_flags=4'b1011; sticky_ovf=1 after the pop; res_count=1.
- Hold out_ready=0 and push 3 values A=16'h1111, B=16'h2222, C=16'h3333 on consecutive cycles → in_ready drops to 0 after B and C is not accepted; after out_ready=1 the outputs are A then B in order.
- With occupancy=1, assert push and pop in the same cycle with 16'h00FF → occupancy stays 1, the head becomes 16'h00FF, and res_count increments by 1.
- Pop an entry with V=1 in the same cycle as clr_sticky=1 → sticky_ovf=1; next cycle clr_sticky=1 alone → sticky_ovf=0.
- Preload res_count to 16'hFFFF via 65535 pops (or force), then 1 more pop → res_count=0. Assert rst while FULL → out_valid=0 and in_ready=1 the following cycle.
